ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative HI/LO multiply/divide unit in the EX stage, directly upstream of the data-memory stage. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle. It holds the architectural HI and LO registers and raises a stall request that freezes IF/ID/EX while an operation is in flight.

## Interface
- DATA_WIDTH, 32, operand/HI/LO width; counter and latency scale with it.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- W_EX_muldiv_op  in  3  operation code:
  - 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
  - 111 is reserved and is treated as none.
- W_EX_rs_data  in  DATA_WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source).
- W_EX_rt_data  in  DATA_WIDTH  rt operand (multiplier/divisor).
- W_EX_flush  in  1  pipeline flush; aborts any in-flight operation.
- W_hi  out  DATA_WIDTH  HI register; read by MFHI.
- W_lo  out  DATA_WIDTH  LO register; read by MFLO.
- W_muldiv_stall  out  1  stall request to the hazard unit.
- W_muldiv_done  out  1  one-cycle pulse when HI/LO have just been written by a mul/div.

## Operation
- States:
  - IDLE: accept new operations.
  - CALC: DATA_WIDTH iterations, one per cycle.
  - FIX: sign correction and HI/LO write.
  - DONE: one cycle, all ops ignored.
- IDLE, op ∈ {MULT, MULTU, DIV, DIVU}, no flush:
  - Capture the operand magnitudes (absolute values for signed ops, raw values for unsigned).
  - Capture the result signs; clear the iteration counter.
  - Go to CALC.
- IDLE, op = MTHI/MTLO, no flush: write rs into HI/LO at that edge; stay in IDLE.
- CALC:
  - MUL: radix-2 shift-add into a 2×DATA_WIDTH accumulator.
  - DIV: restoring division, one quotient bit per cycle.
  - After DATA_WIDTH iterations, go to FIX.
- FIX:
  - Signed MUL: negate the 64-bit product if the operand signs differ.
  - Signed DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - MUL writes HI = product[63:32] and LO = product[31:0].
  - DIV writes LO = quotient and HI = remainder.
  - Go to DONE.
- DONE: assert done; go to IDLE. Any op present this cycle is ignored. That op is the same instruction still held in EX, and it must not restart.
- Divide by zero (both DIV and DIVU): LO = all ones, HI = raw rs. The latency is the normal one.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. No trap is raised.
- Flush has priority over everything:
  - Next state is IDLE.
  - HI/LO are unchanged and any start or MTHI/MTLO in that cycle is dropped.
  - done is not pulsed.
- Reset: state IDLE, HI = LO = 0, counter = 0.
- Reset outputs: W_muldiv_stall = 0, W_muldiv_done = 0.

## Timing
- W_muldiv_stall is combinational. It is 1 when state ∈ {CALC, FIX}, or when state = IDLE with a mul/div op and no flush. It is 0 in DONE.
- Mul/div latency: the op is accepted at edge E0.
  - Edges E1–E32 perform the iterations; FIX is entered at E32.
  - HI/LO are written at E33; done = 1 during the cycle after E33 (DONE).
  - Stall is high for 34 cycles in total: the accept cycle plus 33 busy cycles.
- An instruction in EX during the cycle after DONE sees the new HI/LO (MFHI/MFLO correct with no extra forwarding).
- MTHI/MTLO: the value is visible on W_hi/W_lo in the cycle after the edge; no stall.
- Back-to-back mul/div ops each pay full latency. The second is accepted in the IDLE cycle following DONE.
- Asynchronous reset mid-CALC: outputs go immediately to their reset values; the partial result is discarded.

## Test plan
- Reset during CALC → W_hi = W_lo = 0, stall = 0 immediately, before the next edge; the unit then accepts a new op.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF →
  - Stall is high for exactly 34 cycles.
  - HI = 0xFFFFFFFE, LO = 0x00000001.
  - done pulses for one cycle.
  - The held op during DONE does not restart.
- MULT rs=0xFFFFFFFD (−3), rt=7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB (−21).
- DIV rs=0xFFFFFFF9 (−7), rt=2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Then DIVU rs=100, rt=0 → LO = 0xFFFFFFFF, HI = 100.
- MTHI rs=0x12345678, then MTLO rs=0xCAFEBABE on consecutive cycles → each value is visible the cycle after its edge; stall stays 0.
- MULT started, then W_EX_flush asserted at cycle 10 → IDLE next cycle, HI/LO keep their prior values, no done pulse. A flush in the same cycle as MTLO → LO unchanged.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide unit bus: operation request from EX, HI/LO and
// stall/done status back to the pipeline.
interface ex_muldiv_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [2:0]            W_EX_muldiv_op;
    logic [DATA_WIDTH-1:0] W_EX_rs_data;
    logic [DATA_WIDTH-1:0] W_EX_rt_data;
    logic                  W_EX_flush;
    logic [DATA_WIDTH-1:0] W_hi;
    logic [DATA_WIDTH-1:0] W_lo;
    logic                  W_muldiv_stall;
    logic                  W_muldiv_done;

    modport master (
        output W_EX_muldiv_op, W_EX_rs_data, W_EX_rt_data, W_EX_flush,
        input  W_hi, W_lo, W_muldiv_stall, W_muldiv_done
    );

    modport slave (
        input  W_EX_muldiv_op, W_EX_rs_data, W_EX_rt_data, W_EX_flush,
        output W_hi, W_lo, W_muldiv_stall, W_muldiv_done
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with a final
// sign-fix cycle that writes HI/LO.
module ex_muldiv #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    ex_muldiv_if.slave   bus
);
    localparam int unsigned DW   = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH);

    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*DW-1:0] acc_q, acc_d;       // mul: {partial product, multiplier}; div: {rem, quotient}
    logic [DW-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [DW-1:0]   rs_raw_q, rs_raw_d; // raw dividend, returned in HI on divide by zero
    logic            is_div_q, is_div_d;
    logic            neg_q, neg_d;       // product/quotient sign
    logic            rem_neg_q, rem_neg_d;
    logic            div_zero_q, div_zero_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;

    logic [2:0]      op;
    logic            flush;
    logic [DW-1:0]   rs, rt;
    logic            is_start, is_signed, rs_neg, rt_neg;
    logic [DW-1:0]   rs_mag, rt_mag;
    logic [DW:0]     mul_sum;
    logic [DW:0]     div_diff;
    logic [2*DW-1:0] mul_next, div_next;
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo_fix, rem_fix;

    assign op    = bus.W_EX_muldiv_op;
    assign flush = bus.W_EX_flush;
    assign rs    = bus.W_EX_rs_data;
    assign rt    = bus.W_EX_rt_data;

    assign is_start  = (op == OpMult) || (op == OpMultu) || (op == OpDiv) || (op == OpDivu);
    assign is_signed = (op == OpMult) || (op == OpDiv);
    assign rs_neg    = is_signed & rs[DW-1];
    assign rt_neg    = is_signed & rt[DW-1];
    assign rs_mag    = rs_neg ? -rs : rs;
    assign rt_mag    = rt_neg ? -rt : rt;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[DW-1:1]};

    // Restoring step: shifted remainder minus divisor; no borrow means it fits.
    assign div_diff = acc_q[2*DW-1:DW-1] - {1'b0, opnd_q};
    assign div_next = div_diff[DW] ? {acc_q[2*DW-2:0], 1'b0}
                                   : {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
    assign rem_fix  = rem_neg_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];

    // Next-state: flush overrides everything; DONE ignores the held op.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        rs_raw_d   = rs_raw_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_start) begin
                        is_div_d   = (op == OpDiv) || (op == OpDivu);
                        neg_d      = rs_neg ^ rt_neg;
                        rem_neg_d  = rs_neg;
                        div_zero_d = (rt == '0);
                        rs_raw_d   = rs;
                        cnt_d      = '0;
                        if ((op == OpDiv) || (op == OpDivu)) begin
                            acc_d  = {{DW{1'b0}}, rs_mag};
                            opnd_d = rt_mag;
                        end else begin
                            acc_d  = {{DW{1'b0}}, rt_mag};
                            opnd_d = rs_mag;
                        end
                        state_d = StCalc;
                    end else if (op == OpMthi) begin
                        hi_d = rs;
                    end else if (op == OpMtlo) begin
                        lo_d = rs;
                    end
                end
                StCalc: begin
                    cnt_d = cnt_q + CntW'(1);
                    acc_d = is_div_q ? div_next : mul_next;
                    if (cnt_q == CntW'(DW - 1)) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*DW-1:DW];
                        lo_d = prod_fix[DW-1:0];
                    end else if (div_zero_q) begin
                        hi_d = rs_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                    state_d = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            rs_raw_q   <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            rs_raw_q   <= rs_raw_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign bus.W_hi          = hi_q;
    assign bus.W_lo          = lo_q;
    assign bus.W_muldiv_done = (state_q == StDone);
    // Reset masks the accept-cycle term so stall drops at once even if EX still holds an op.
    assign bus.W_muldiv_stall = ~rst & ((state_q == StCalc) || (state_q == StFix) ||
                                        ((state_q == StIdle) && is_start && !flush));
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, results, MTHI/MTLO, flush and reset.
module tb_ex_muldiv;
    localparam logic [2:0] OpNone  = 3'b000;
    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpMultu = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpDivu  = 3'b100;
    localparam logic [2:0] OpMthi  = 3'b101;
    localparam logic [2:0] OpMtlo  = 3'b110;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_muldiv_if #(.DATA_WIDTH(32)) bus ();

    ex_muldiv #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue a mul/div, hold it in EX until the edge that leaves DONE, then clear it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int stall_cycles, output logic early_done,
                          output logic done_in, output logic done_after,
                          output logic stall_after);
        @(negedge clk);
        bus.W_EX_muldiv_op = op;
        bus.W_EX_rs_data   = rs;
        bus.W_EX_rt_data   = rt;
        #1;
        stall_cycles = 0;
        early_done   = 1'b0;
        while (bus.W_muldiv_stall && stall_cycles < 100) begin
            stall_cycles++;
            if (bus.W_muldiv_done) early_done = 1'b1;
            @(negedge clk);
            #1;
        end
        done_in = bus.W_muldiv_done;
        @(negedge clk);
        bus.W_EX_muldiv_op = OpNone;
        #1;
        done_after  = bus.W_muldiv_done;
        stall_after = bus.W_muldiv_stall;
    endtask

    task automatic test_reset;
        n_checks++;
        if (bus.W_hi !== 32'h0) begin
            n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.W_hi, 32'h0);
        end
        n_checks++;
        if (bus.W_lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_lo: got %h expected %h", bus.W_lo, 32'h0);
        end
        n_checks++;
        if (bus.W_muldiv_stall !== 1'b0 || bus.W_muldiv_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got stall=%b done=%b expected 0 0",
                     bus.W_muldiv_stall, bus.W_muldiv_done);
        end
    endtask

    task automatic test_multu;
        int sc; logic ed, di, da, sa;
        run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, sc, ed, di, da, sa);
        n_checks++;
        if (sc !== 34) begin
            n_fail++; $display("FAIL multu_stall_len: got %0d expected 34", sc);
        end
        n_checks++;
        if (ed !== 1'b0 || di !== 1'b1 || da !== 1'b0) begin
            n_fail++;
            $display("FAIL multu_done_pulse: got early=%b in=%b after=%b expected 0 1 0",
                     ed, di, da);
        end
        n_checks++;
        if (sa !== 1'b0) begin
            n_fail++; $display("FAIL multu_no_restart: got stall=%b expected 0", sa);
        end
        n_checks++;
        if (bus.W_hi !== 32'hFFFF_FFFE || bus.W_lo !== 32'h0000_0001) begin
            n_fail++;
            $display("FAIL multu_result: got %h_%h expected fffffffe_00000001",
                     bus.W_hi, bus.W_lo);
        end
    endtask

    task automatic test_mult;
        int sc; logic ed, di, da, sa;
        run_op(OpMult, 32'hFFFF_FFFD, 32'h0000_0007, sc, ed, di, da, sa);
        n_checks++;
        if (bus.W_hi !== 32'hFFFF_FFFF || bus.W_lo !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mult_neg: got %h_%h expected ffffffff_ffffffeb", bus.W_hi, bus.W_lo);
        end
        n_checks++;
        if (sc !== 34 || di !== 1'b1) begin
            n_fail++; $display("FAIL mult_timing: got stall=%0d done=%b expected 34 1", sc, di);
        end
    endtask

    task automatic test_div;
        int sc; logic ed, di, da, sa;
        run_op(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, sc, ed, di, da, sa);
        n_checks++;
        if (bus.W_lo !== 32'hFFFF_FFFD || bus.W_hi !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL div_neg: got lo=%h hi=%h expected lo=fffffffd hi=ffffffff",
                     bus.W_lo, bus.W_hi);
        end
        // Back-to-back: next op accepted in the IDLE cycle after DONE.
        run_op(OpDivu, 32'd100, 32'd0, sc, ed, di, da, sa);
        n_checks++;
        if (bus.W_lo !== 32'hFFFF_FFFF || bus.W_hi !== 32'd100) begin
            n_fail++;
            $display("FAIL divu_zero: got lo=%h hi=%h expected lo=ffffffff hi=00000064",
                     bus.W_lo, bus.W_hi);
        end
        n_checks++;
        if (sc !== 34) begin
            n_fail++; $display("FAIL divu_zero_latency: got %0d expected 34", sc);
        end
        run_op(OpDiv, 32'hFFFF_FFFB, 32'd0, sc, ed, di, da, sa);
        n_checks++;
        if (bus.W_lo !== 32'hFFFF_FFFF || bus.W_hi !== 32'hFFFF_FFFB) begin
            n_fail++;
            $display("FAIL div_zero_signed: got lo=%h hi=%h expected lo=ffffffff hi=fffffffb",
                     bus.W_lo, bus.W_hi);
        end
        run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, sc, ed, di, da, sa);
        n_checks++;
        if (bus.W_lo !== 32'h8000_0000 || bus.W_hi !== 32'h0) begin
            n_fail++;
            $display("FAIL div_overflow: got lo=%h hi=%h expected lo=80000000 hi=00000000",
                     bus.W_lo, bus.W_hi);
        end
        run_op(OpDivu, 32'd1000, 32'd7, sc, ed, di, da, sa);
        n_checks++;
        if (bus.W_lo !== 32'd142 || bus.W_hi !== 32'd6) begin
            n_fail++;
            $display("FAIL divu_basic: got lo=%h hi=%h expected lo=0000008e hi=00000006",
                     bus.W_lo, bus.W_hi);
        end
    endtask

    task automatic test_mthi_mtlo;
        logic s0, s1;
        @(negedge clk);
        bus.W_EX_muldiv_op = OpMthi;
        bus.W_EX_rs_data   = 32'h1234_5678;
        #1;
        s0 = bus.W_muldiv_stall;
        @(negedge clk);
        bus.W_EX_muldiv_op = OpMtlo;
        bus.W_EX_rs_data   = 32'hCAFE_BABE;
        #1;
        s1 = bus.W_muldiv_stall;
        n_checks++;
        if (bus.W_hi !== 32'h1234_5678) begin
            n_fail++; $display("FAIL mthi: got %h expected 12345678", bus.W_hi);
        end
        @(negedge clk);
        bus.W_EX_muldiv_op = OpNone;
        #1;
        n_checks++;
        if (bus.W_lo !== 32'hCAFE_BABE || bus.W_hi !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL mtlo: got lo=%h hi=%h expected lo=cafebabe hi=12345678",
                     bus.W_lo, bus.W_hi);
        end
        n_checks++;
        if (s0 !== 1'b0 || s1 !== 1'b0) begin
            n_fail++; $display("FAIL mt_stall: got %b %b expected 0 0", s0, s1);
        end
    endtask

    task automatic test_flush;
        logic saw_done;
        // Flush on the accept cycle drops the start and the stall.
        @(negedge clk);
        bus.W_EX_muldiv_op = OpMult;
        bus.W_EX_rs_data   = 32'd5;
        bus.W_EX_rt_data   = 32'd6;
        bus.W_EX_flush     = 1'b1;
        #1;
        n_checks++;
        if (bus.W_muldiv_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_accept_stall: got %b expected 0", bus.W_muldiv_stall);
        end
        bus.W_EX_flush = 1'b0;
        // Start for real, then flush at cycle 10.
        @(negedge clk);
        bus.W_EX_muldiv_op = OpNone;
        for (int i = 0; i < 9; i++) @(negedge clk);
        bus.W_EX_flush = 1'b1;
        @(negedge clk);
        bus.W_EX_flush = 1'b0;
        #1;
        n_checks++;
        if (bus.W_muldiv_stall !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: got stall=%b expected 0", bus.W_muldiv_stall);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.W_muldiv_done) saw_done = 1'b1;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (saw_done !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_done: got done seen=%b expected 0", saw_done);
        end
        n_checks++;
        if (bus.W_hi !== 32'h1234_5678 || bus.W_lo !== 32'hCAFE_BABE) begin
            n_fail++;
            $display("FAIL flush_hilo_kept: got %h_%h expected 12345678_cafebabe",
                     bus.W_hi, bus.W_lo);
        end
        bus.W_EX_muldiv_op = OpMtlo;
        bus.W_EX_rs_data   = 32'hDEAD_BEEF;
        bus.W_EX_flush     = 1'b1;
        @(negedge clk);
        bus.W_EX_muldiv_op = OpNone;
        bus.W_EX_flush     = 1'b0;
        #1;
        n_checks++;
        if (bus.W_lo !== 32'hCAFE_BABE) begin
            n_fail++; $display("FAIL flush_mtlo: got %h expected cafebabe", bus.W_lo);
        end
    endtask

    task automatic test_reset_mid_calc;
        int sc; logic ed, di, da, sa;
        @(negedge clk);
        bus.W_EX_muldiv_op = OpMultu;
        bus.W_EX_rs_data   = 32'd9;
        bus.W_EX_rt_data   = 32'd9;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.W_hi !== 32'h0 || bus.W_lo !== 32'h0 || bus.W_muldiv_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_calc: got hi=%h lo=%h stall=%b expected 0 0 0",
                     bus.W_hi, bus.W_lo, bus.W_muldiv_stall);
        end
        bus.W_EX_muldiv_op = OpNone;
        @(negedge clk);
        rst = 1'b0;
        run_op(OpMultu, 32'd3, 32'd4, sc, ed, di, da, sa);
        n_checks++;
        if (bus.W_hi !== 32'h0 || bus.W_lo !== 32'd12 || sc !== 34) begin
            n_fail++;
            $display("FAIL after_reset_op: got hi=%h lo=%h stall=%0d expected 0 c 34",
                     bus.W_hi, bus.W_lo, sc);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst                = 1'b1;
        bus.W_EX_muldiv_op = OpNone;
        bus.W_EX_rs_data   = '0;
        bus.W_EX_rt_data   = '0;
        bus.W_EX_flush     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_flush();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
